multicycle_core: RTL and testbench
==================================

MULTICYCLE_CORE -- requirements
Module: multicycle_core

Interface
REQ-001 Parameter XLEN, default 32: datapath, register and memory-bus width in bits; legal values 32 and 64.
REQ-002 Parameter NREGS, default 32: architectural register count; legal values 16 (RV32E) and 32; x0 hard-wired to zero.
REQ-003 Parameter RESET_PC, default 0: PC value loaded on reset.
REQ-004 Ports: clk in 1 (system clock); rst in 1 (active-high asynchronous reset).
REQ-005 Ports: mem_req out 1 (memory request); mem_we out 1 (write enable); mem_addr out XLEN (byte address); mem_wdata out XLEN (store data).
REQ-006 Ports: mem_rdata in XLEN (read data, valid with mem_ready); mem_ready in 1 (request completes this cycle).
REQ-007 Ports: pc out XLEN (current PC); halted out 1 (core stopped on illegal instruction); instret out 32 (retired count; present only with macro).

Function
REQ-008 Core SHALL implement one unified memory port; fetch and data accesses SHALL share it.
REQ-009 Supported set: ADD SUB AND OR XOR SLT SLL SRL; ADDI ANDI ORI XORI SLTI; LW; SW; BEQ; BNE; JAL.
REQ-010 FSM states: FETCH, DECODE, EXEC, MEM, WB, HALT.
REQ-011 FETCH: mem_req=1, mem_we=0, mem_addr=pc; on mem_ready, latch IR and go to DECODE; otherwise stay.
REQ-012 DECODE: read rs1/rs2 into A/B; generate immediate; illegal opcode or register index >= NREGS -> HALT.
REQ-013 EXEC, ALU ops: compute into ALUOut -> WB.
REQ-014 EXEC, LW/SW: ALUOut = A + imm -> MEM.
REQ-015 EXEC, BEQ/BNE: pc = taken ? pc+imm : pc+4 -> FETCH.
REQ-016 EXEC, JAL: ALUOut = pc+4; pc = pc+imm -> WB.
REQ-017 MEM: mem_req=1, mem_addr=ALUOut, mem_we=1 for SW with mem_wdata=B; hold all outputs stable until mem_ready.
REQ-018 MEM on mem_ready: LW latches MDR -> WB; SW does pc += 4 -> FETCH.
REQ-019 WB: write rd (ALUOut or MDR); writes to x0 discarded; pc += 4 except JAL -> FETCH.
REQ-020 mem_req SHALL be 0 outside FETCH/MEM; mem_we SHALL be 0 except SW MEM.
REQ-021 Arithmetic modulo 2^XLEN; shift amount = low log2(XLEN) bits; SLT/SLTI signed.
REQ-022 PC wraps modulo 2^XLEN; misaligned addresses passed unchanged.
REQ-023 HALT is absorbing until reset: halted=1, mem_req=0.
REQ-024 Instruction latency with zero-wait memory: ALU/JAL 4 cycles, LW 5, SW 4, branch 3; each wait cycle adds one.

Reset
REQ-025 rst asserted SHALL immediately force: state=FETCH; pc=RESET_PC; registers zero; IR/A/B/ALUOut/MDR zero; halted=0; instret=0.
REQ-026 Reset during MEM abandons the access; mem_req and mem_we drop in the same cycle, asynchronously.

Configuration
REQ-027 With MULTICYCLE_CORE_INSTRET_EN defined, instret increments on every FETCH entry that follows a completed instruction and wraps at 2^32.
REQ-028 Without MULTICYCLE_CORE_INSTRET_EN, neither the instret port nor the counter exists.

Structure
REQ-029 Shared package: opcode/funct3/funct7 constants, state enum, ALU-op enum, immediate-type enum.
REQ-030 One sub-module, mc_alu (combinational, XLEN-parameterised); register file inlined.

Verification
REQ-031 Reset, mem_ready=1: first access mem_addr=RESET_PC, mem_req=1 in cycle 1, mem_we=0.
REQ-032 ADDI x1,x0,5; ADDI x2,x0,-3; ADD x3,x1,x2 -> x3=2; SLT x4,x2,x1 -> x4=1; instret=4 after fourth retire.
REQ-033 SW x3,8(x0) then LW x5,8(x0), memory with 2 wait states -> write addr 8 data 2 held 3 cycles; x5=2; LW takes 7 cycles.
REQ-034 BEQ x1,x1,+8 -> next fetch pc+8; BNE x1,x1,+8 -> pc+4; JAL x1,-4 -> x1=pc+4, next fetch pc-4.
REQ-035 Opcode 0x7F -> halted=1 after DECODE; mem_req stays 0; rst clears halted; fetch resumes at RESET_PC.
REQ-036 NREGS=16, ADD x20,... -> HALT. Separately, rst mid-MEM -> mem_req=0 the same cycle.

Source files
------------

// File: rtl/multicycle_core_pkg.sv
// Shared encodings, FSM state codes and decode enums for multicycle_core.
// Optional retired-instruction counter: define MULTICYCLE_CORE_INSTRET_EN.
package multicycle_core_pkg;

    localparam logic [6:0] OPC_OP     = 7'h33;
    localparam logic [6:0] OPC_OP_IMM = 7'h13;
    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_BRANCH = 7'h63;
    localparam logic [6:0] OPC_JAL    = 7'h6F;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL     = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;
    localparam logic [2:0] F3_WORD    = 3'b010;
    localparam logic [2:0] F3_BEQ     = 3'b000;
    localparam logic [2:0] F3_BNE     = 3'b001;

    localparam logic [6:0] F7_BASE = 7'h00;
    localparam logic [6:0] F7_ALT  = 7'h20;

    typedef logic [2:0] state_t;
    localparam state_t ST_FETCH  = 3'd0;
    localparam state_t ST_DECODE = 3'd1;
    localparam state_t ST_EXEC   = 3'd2;
    localparam state_t ST_MEM    = 3'd3;
    localparam state_t ST_WB     = 3'd4;
    localparam state_t ST_HALT   = 3'd5;

    typedef enum logic [2:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLT, ALU_SLL, ALU_SRL
    } alu_op_t;

    typedef enum logic [2:0] {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_J} imm_type_t;

    typedef enum logic [2:0] {
        CLS_ALU, CLS_LOAD, CLS_STORE, CLS_BRANCH, CLS_JAL, CLS_ILLEGAL
    } inst_class_t;

    // Sign-extended 32-bit immediate; the core widens it to XLEN.
    function automatic logic [31:0] gen_imm(input logic [31:0] ir, input imm_type_t t);
        case (t)
            IMM_I:   return {{20{ir[31]}}, ir[31:20]};
            IMM_S:   return {{20{ir[31]}}, ir[31:25], ir[11:7]};
            IMM_B:   return {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
            IMM_J:   return {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
            default: return 32'd0;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_core_alu.sv
// Combinational XLEN-wide ALU used for register ops and address generation.
module mc_alu
    import multicycle_core_pkg::*;
#(
    parameter int XLEN = 32
)(
    input  alu_op_t          op,
    input  logic [XLEN-1:0]  a,
    input  logic [XLEN-1:0]  b,
    output logic [XLEN-1:0]  y
);
    localparam int SHW = $clog2(XLEN);

    logic [SHW-1:0] shamt_s;
    assign shamt_s = b[SHW-1:0];

    // Operation select; SLT compares as signed.
    always_comb begin
        y = '0;
        case (op)
            ALU_ADD: y = a + b;
            ALU_SUB: y = a - b;
            ALU_AND: y = a & b;
            ALU_OR:  y = a | b;
            ALU_XOR: y = a ^ b;
            ALU_SLT: y = XLEN'($signed(a) < $signed(b));
            ALU_SLL: y = a << shamt_s;
            ALU_SRL: y = a >> shamt_s;
            default: y = '0;
        endcase
    end
endmodule

// File: rtl/multicycle_core.sv
// Multi-cycle RV32I-subset core with one shared memory port.
// Define MULTICYCLE_CORE_INSTRET_EN to add the instret counter and port.
module multicycle_core
    import multicycle_core_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              NREGS    = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
)(
    input  logic             clk,
    input  logic             rst,
    output logic             mem_req,
    output logic             mem_we,
    output logic [XLEN-1:0]  mem_addr,
    output logic [XLEN-1:0]  mem_wdata,
    input  logic [XLEN-1:0]  mem_rdata,
    input  logic             mem_ready,
    output logic [XLEN-1:0]  pc,
    output logic             halted
`ifdef MULTICYCLE_CORE_INSTRET_EN
    ,
    output logic [31:0]      instret
`endif
);
    localparam int              RW      = $clog2(NREGS);
    localparam logic [5:0]      NREGS_W = 6'(NREGS);
    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    state_t            state_r;
    logic [XLEN-1:0]   pc_r, a_r, b_r, imm_r, alu_out_r, mdr_r;
    logic [31:0]       ir_r;
    logic [XLEN-1:0]   regs_r [NREGS];

    logic [6:0]  opcode_s, f7_s;
    logic [2:0]  f3_s;
    logic [4:0]  rd_s, rs1_s, rs2_s;
    inst_class_t cls_s;
    alu_op_t     alu_op_s;
    imm_type_t   imm_type_s;
    logic        use_rs1_s, use_rs2_s, use_rd_s, bad_reg_s, legal_s, taken_s;
    logic [XLEN-1:0] imm_s, alu_b_s, alu_y_s;

    assign opcode_s = ir_r[6:0];
    assign rd_s     = ir_r[11:7];
    assign f3_s     = ir_r[14:12];
    assign rs1_s    = ir_r[19:15];
    assign rs2_s    = ir_r[24:20];
    assign f7_s     = ir_r[31:25];

    // Instruction class, ALU operation, immediate format and register usage.
    always_comb begin
        cls_s      = CLS_ILLEGAL;
        alu_op_s   = ALU_ADD;
        imm_type_s = IMM_NONE;
        use_rs1_s  = 1'b0;
        use_rs2_s  = 1'b0;
        use_rd_s   = 1'b0;
        case (opcode_s)
            OPC_OP: begin
                use_rs1_s = 1'b1;
                use_rs2_s = 1'b1;
                use_rd_s  = 1'b1;
                if (f7_s == F7_BASE) begin
                    cls_s = CLS_ALU;
                    case (f3_s)
                        F3_ADD_SUB: alu_op_s = ALU_ADD;
                        F3_SLL:     alu_op_s = ALU_SLL;
                        F3_SLT:     alu_op_s = ALU_SLT;
                        F3_XOR:     alu_op_s = ALU_XOR;
                        F3_SRL:     alu_op_s = ALU_SRL;
                        F3_OR:      alu_op_s = ALU_OR;
                        F3_AND:     alu_op_s = ALU_AND;
                        default:    cls_s    = CLS_ILLEGAL;
                    endcase
                end else if (f7_s == F7_ALT && f3_s == F3_ADD_SUB) begin
                    cls_s    = CLS_ALU;
                    alu_op_s = ALU_SUB;
                end else begin
                    cls_s = CLS_ILLEGAL;
                end
            end
            OPC_OP_IMM: begin
                use_rs1_s  = 1'b1;
                use_rd_s   = 1'b1;
                imm_type_s = IMM_I;
                cls_s      = CLS_ALU;
                case (f3_s)
                    F3_ADD_SUB: alu_op_s = ALU_ADD;
                    F3_SLT:     alu_op_s = ALU_SLT;
                    F3_XOR:     alu_op_s = ALU_XOR;
                    F3_OR:      alu_op_s = ALU_OR;
                    F3_AND:     alu_op_s = ALU_AND;
                    default:    cls_s    = CLS_ILLEGAL;
                endcase
            end
            OPC_LOAD: begin
                use_rs1_s  = 1'b1;
                use_rd_s   = 1'b1;
                imm_type_s = IMM_I;
                cls_s      = (f3_s == F3_WORD) ? CLS_LOAD : CLS_ILLEGAL;
            end
            OPC_STORE: begin
                use_rs1_s  = 1'b1;
                use_rs2_s  = 1'b1;
                imm_type_s = IMM_S;
                cls_s      = (f3_s == F3_WORD) ? CLS_STORE : CLS_ILLEGAL;
            end
            OPC_BRANCH: begin
                use_rs1_s  = 1'b1;
                use_rs2_s  = 1'b1;
                imm_type_s = IMM_B;
                cls_s      = (f3_s == F3_BEQ || f3_s == F3_BNE) ? CLS_BRANCH : CLS_ILLEGAL;
            end
            OPC_JAL: begin
                use_rd_s   = 1'b1;
                imm_type_s = IMM_J;
                cls_s      = CLS_JAL;
            end
            default: cls_s = CLS_ILLEGAL;
        endcase
    end

    assign bad_reg_s = (use_rs1_s && ({1'b0, rs1_s} >= NREGS_W)) ||
                       (use_rs2_s && ({1'b0, rs2_s} >= NREGS_W)) ||
                       (use_rd_s  && ({1'b0, rd_s}  >= NREGS_W));
    assign legal_s   = (cls_s != CLS_ILLEGAL) && !bad_reg_s;
    assign imm_s     = XLEN'($signed(gen_imm(ir_r, imm_type_s)));
    assign alu_b_s   = (opcode_s == OPC_OP) ? b_r : imm_r;
    assign taken_s   = (a_r == b_r) ^ (f3_s == F3_BNE);

    mc_alu #(.XLEN(XLEN)) u_alu (
        .op (alu_op_s),
        .a  (a_r),
        .b  (alu_b_s),
        .y  (alu_y_s)
    );

    // Sequencer and architectural state; x0 is never written so it reads zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_FETCH;
            pc_r      <= RESET_PC;
            ir_r      <= 32'd0;
            a_r       <= '0;
            b_r       <= '0;
            imm_r     <= '0;
            alu_out_r <= '0;
            mdr_r     <= '0;
            for (int i = 0; i < NREGS; i++) regs_r[i] <= '0;
        end else begin
            case (state_r)
                ST_FETCH: begin
                    if (mem_ready) begin
                        ir_r    <= mem_rdata[31:0];
                        state_r <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    if (legal_s) begin
                        a_r     <= regs_r[rs1_s[RW-1:0]];
                        b_r     <= regs_r[rs2_s[RW-1:0]];
                        imm_r   <= imm_s;
                        state_r <= ST_EXEC;
                    end else begin
                        state_r <= ST_HALT;
                    end
                end
                ST_EXEC: begin
                    case (cls_s)
                        CLS_ALU: begin
                            alu_out_r <= alu_y_s;
                            state_r   <= ST_WB;
                        end
                        CLS_LOAD, CLS_STORE: begin
                            alu_out_r <= alu_y_s;
                            state_r   <= ST_MEM;
                        end
                        CLS_BRANCH: begin
                            pc_r    <= taken_s ? pc_r + imm_r : pc_r + PC_STEP;
                            state_r <= ST_FETCH;
                        end
                        CLS_JAL: begin
                            alu_out_r <= pc_r + PC_STEP;
                            pc_r      <= pc_r + imm_r;
                            state_r   <= ST_WB;
                        end
                        default: state_r <= ST_HALT;
                    endcase
                end
                ST_MEM: begin
                    if (mem_ready) begin
                        if (cls_s == CLS_LOAD) begin
                            mdr_r   <= mem_rdata;
                            state_r <= ST_WB;
                        end else begin
                            pc_r    <= pc_r + PC_STEP;
                            state_r <= ST_FETCH;
                        end
                    end
                end
                ST_WB: begin
                    if (rd_s != 5'd0) begin
                        regs_r[rd_s[RW-1:0]] <= (cls_s == CLS_LOAD) ? mdr_r : alu_out_r;
                    end
                    if (cls_s != CLS_JAL) begin
                        pc_r <= pc_r + PC_STEP;
                    end
                    state_r <= ST_FETCH;
                end
                ST_HALT: state_r <= ST_HALT;
                default: state_r <= ST_HALT;
            endcase
        end
    end

    // Bus drive; rst gates the request so an abandoned access drops immediately.
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = pc_r;
        mem_wdata = b_r;
        if (rst) begin
            mem_req = 1'b0;
            mem_we  = 1'b0;
        end else if (state_r == ST_FETCH) begin
            mem_req = 1'b1;
        end else if (state_r == ST_MEM) begin
            mem_req  = 1'b1;
            mem_we   = (cls_s == CLS_STORE);
            mem_addr = alu_out_r;
        end else begin
            mem_req = 1'b0;
        end
    end

    assign pc     = pc_r;
    assign halted = (state_r == ST_HALT);

`ifdef MULTICYCLE_CORE_INSTRET_EN
    logic [31:0] instret_r;
    logic        retire_s;

    assign retire_s = (state_r == ST_EXEC && cls_s == CLS_BRANCH) ||
                      (state_r == ST_MEM && mem_ready && cls_s == CLS_STORE) ||
                      (state_r == ST_WB);

    // Counts completed instructions; wraps naturally at 2^32.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instret_r <= 32'd0;
        end else if (retire_s) begin
            instret_r <= instret_r + 32'd1;
        end
    end

    assign instret = instret_r;
`endif

endmodule

// File: tb/tb_multicycle_core.sv
// Directed self-checking bench for multicycle_core (RESET_PC=0x100).
// Code lives at 0x100..0x1FF with zero waits; data below 0x100 uses dwait waits.
module tb_multicycle_core;

    localparam logic [31:0] RPC  = 32'h100;
    localparam logic [31:0] HALT = 32'h0000007F;
    localparam int          OPI  = 7'h13;

    logic        clk, rst;
    logic        mem_req, mem_we, mem_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, pc;
    logic        halted;
    logic        req16, we16, halted16;
    logic [31:0] addr16, wdata16, pc16;
`ifdef MULTICYCLE_CORE_INSTRET_EN
    logic [31:0] instret, instret16;
`endif

    logic [31:0] imem [64];
    logic [31:0] dmem [64];
    logic [31:0] prog [$];
    logic [31:0] fetch_q [$];
    int          fcyc_q [$];
    int          dwait, wcnt, cyc, we_cnt, fq_base, we_base;
    logic [31:0] we_addr, we_data, ioff;
    logic        is_data;
    int          tests, fails;

    multicycle_core #(.XLEN(32), .NREGS(32), .RESET_PC(RPC)) dut (
        .clk(clk), .rst(rst), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready), .pc(pc), .halted(halted)
`ifdef MULTICYCLE_CORE_INSTRET_EN
        , .instret(instret)
`endif
    );

    multicycle_core #(.XLEN(32), .NREGS(16), .RESET_PC(RPC)) dut16 (
        .clk(clk), .rst(rst), .mem_req(req16), .mem_we(we16),
        .mem_addr(addr16), .mem_wdata(wdata16), .mem_rdata(32'h00208A33),
        .mem_ready(1'b1), .pc(pc16), .halted(halted16)
`ifdef MULTICYCLE_CORE_INSTRET_EN
        , .instret(instret16)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: instant code fetch, dwait wait states on data accesses.
    always_comb begin
        is_data   = (mem_addr < RPC);
        ioff      = mem_addr - RPC;
        mem_rdata = is_data ? dmem[mem_addr[7:2]] : imem[ioff[7:2]];
        mem_ready = mem_req && (is_data ? (wcnt == dwait) : 1'b1);
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_req && !mem_ready) wcnt <= wcnt + 1;
        else wcnt <= 0;
        if (mem_req && mem_we && mem_ready && is_data) dmem[mem_addr[7:2]] <= mem_wdata;
    end

    // Fetch log and store observation, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst && mem_req && mem_ready && !mem_we && !is_data) begin
            fetch_q.push_back(mem_addr);
            fcyc_q.push_back(cyc);
        end
        if (mem_req && mem_we) begin
            we_cnt  <= we_cnt + 1;
            we_addr <= mem_addr;
            we_data <= mem_wdata;
        end
    end

    function automatic logic [31:0] enc_r(input int f7, input int rs2, input int rs1, input int f3, input int rd);
        return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'h33};
    endfunction
    function automatic logic [31:0] enc_i(input int imm, input int rs1, input int f3, input int rd, input int opc);
        logic [31:0] v = imm;
        return {v[11:0], 5'(rs1), 3'(f3), 5'(rd), 7'(opc)};
    endfunction
    function automatic logic [31:0] enc_s(input int imm, input int rs2, input int rs1);
        logic [31:0] v = imm;
        return {v[11:5], 5'(rs2), 5'(rs1), 3'b010, v[4:0], 7'h23};
    endfunction
    function automatic logic [31:0] enc_b(input int imm, input int rs2, input int rs1, input int f3);
        logic [31:0] v = imm;
        return {v[12], v[10:5], 5'(rs2), 5'(rs1), 3'(f3), v[4:1], v[11], 7'h63};
    endfunction
    function automatic logic [31:0] enc_j(input int imm, input int rd);
        logic [31:0] v = imm;
        return {v[20], v[10:1], v[11], v[19:12], 5'(rd), 7'h6F};
    endfunction

    task automatic start_prog(input int waits);
        rst   = 1'b1;
        dwait = waits;
        for (int i = 0; i < 64; i++) imem[i] = HALT;
        for (int i = 0; i < prog.size(); i++) imem[i] = prog[i];
        repeat (2) @(posedge clk);
        #2;
        rst     = 1'b0;
        fq_base = fetch_q.size();
        we_base = we_cnt;
    endtask

    task automatic wait_halt(input int budget, input string name);
        int n = 0;
        while (!halted && n < budget) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (halted !== 1'b1) begin
            fails++;
            $display("FAIL %s halt timeout: halted=%b expected 1", name, halted);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #3;
        tests++; if (pc !== RPC) begin fails++; $display("FAIL reset_pc: got %h expected %h", pc, RPC); end
        tests++; if (mem_req !== 1'b0) begin fails++; $display("FAIL reset_req: got %b expected 0", mem_req); end
        tests++; if (halted !== 1'b0) begin fails++; $display("FAIL reset_halted: got %b expected 0", halted); end
`ifdef MULTICYCLE_CORE_INSTRET_EN
        tests++; if (instret !== 32'd0) begin fails++; $display("FAIL reset_instret: got %0d expected 0", instret); end
`endif
        prog = '{};
        start_prog(0);
        #1;
        tests++; if (mem_req !== 1'b1) begin fails++; $display("FAIL first_req: got %b expected 1", mem_req); end
        tests++; if (mem_addr !== RPC) begin fails++; $display("FAIL first_addr: got %h expected %h", mem_addr, RPC); end
        tests++; if (mem_we !== 1'b0) begin fails++; $display("FAIL first_we: got %b expected 0", mem_we); end
    endtask

    task automatic test_alu_basic();
        prog = '{enc_i(5, 0, 0, 1, OPI), enc_i(-3, 0, 0, 2, OPI),
                 enc_r(0, 2, 1, 0, 3), enc_r(0, 1, 2, 2, 4)};
        start_prog(0);
        wait_halt(100, "alu_basic");
        tests++; if (dut.regs_r[1] !== 32'd5) begin fails++; $display("FAIL addi_x1: got %h expected 5", dut.regs_r[1]); end
        tests++; if (dut.regs_r[2] !== 32'hFFFFFFFD) begin fails++; $display("FAIL addi_x2: got %h expected fffffffd", dut.regs_r[2]); end
        tests++; if (dut.regs_r[3] !== 32'd2) begin fails++; $display("FAIL add_x3: got %h expected 2", dut.regs_r[3]); end
        tests++; if (dut.regs_r[4] !== 32'd1) begin fails++; $display("FAIL slt_x4: got %h expected 1", dut.regs_r[4]); end
        tests++;
        if (fetch_q.size() < fq_base + 4 || fcyc_q[fq_base + 3] - fcyc_q[fq_base + 2] != 4) begin
            fails++; $display("FAIL add_latency: fetch log too short or latency not 4");
        end
`ifdef MULTICYCLE_CORE_INSTRET_EN
        tests++; if (instret !== 32'd4) begin fails++; $display("FAIL instret_alu: got %0d expected 4", instret); end
`endif
    endtask

    task automatic test_alu_ops();
        int          rix [15] = '{3, 4, 5, 6, 8, 9, 10, 11, 12, 13, 14, 15, 0, 20, 7};
        logic [31:0] exp [15] = '{32'h100, 32'hF0, 32'hFFFFFFF0, 32'hFFFFFF00, 32'hF00,
                                  32'h0FFFFFFF, 32'hF0, 32'hFF, 32'hF, 32'd0, 32'd1,
                                  32'd0, 32'd0, 32'hE0, 32'd36};
        prog = '{enc_i(240, 0, 0, 1, OPI), enc_i(-16, 0, 0, 2, OPI),
                 enc_r(32, 2, 1, 0, 3), enc_r(0, 2, 1, 7, 4), enc_r(0, 2, 1, 6, 5),
                 enc_r(0, 2, 1, 4, 6), enc_i(36, 0, 0, 7, OPI), enc_r(0, 7, 1, 1, 8),
                 enc_r(0, 7, 2, 5, 9), enc_i(255, 2, 7, 10, OPI), enc_i(15, 1, 6, 11, OPI),
                 enc_i(-1, 2, 4, 12, OPI), enc_i(-1, 1, 2, 13, OPI), enc_i(-1, 2, 2, 14, OPI),
                 enc_r(0, 2, 1, 2, 15), enc_i(7, 1, 0, 0, OPI), enc_r(0, 2, 1, 0, 20)};
        start_prog(0);
        wait_halt(200, "alu_ops");
        for (int i = 0; i < 15; i++) begin
            tests++;
            if (dut.regs_r[rix[i]] !== exp[i]) begin
                fails++;
                $display("FAIL alu_ops_x%0d: got %h expected %h", rix[i], dut.regs_r[rix[i]], exp[i]);
            end
        end
    endtask

    task automatic test_mem_waits();
        prog = '{enc_i(5, 0, 0, 1, OPI), enc_i(-3, 0, 0, 2, OPI), enc_r(0, 2, 1, 0, 3),
                 enc_s(8, 3, 0), enc_i(8, 0, 2, 5, 7'h03)};
        start_prog(2);
        wait_halt(200, "mem_waits");
        tests++; if (we_cnt - we_base != 3) begin fails++; $display("FAIL sw_hold: got %0d cycles expected 3", we_cnt - we_base); end
        tests++; if (we_addr !== 32'd8) begin fails++; $display("FAIL sw_addr: got %h expected 8", we_addr); end
        tests++; if (we_data !== 32'd2) begin fails++; $display("FAIL sw_data: got %h expected 2", we_data); end
        tests++; if (dmem[2] !== 32'd2) begin fails++; $display("FAIL sw_mem: got %h expected 2", dmem[2]); end
        tests++; if (dut.regs_r[5] !== 32'd2) begin fails++; $display("FAIL lw_x5: got %h expected 2", dut.regs_r[5]); end
        tests++;
        if (fetch_q.size() < fq_base + 6 || fcyc_q[fq_base + 4] - fcyc_q[fq_base + 3] != 6 ||
            fcyc_q[fq_base + 5] - fcyc_q[fq_base + 4] != 7) begin
            fails++; $display("FAIL mem_latency: expected SW 6 cycles and LW 7 cycles");
        end
`ifdef MULTICYCLE_CORE_INSTRET_EN
        tests++; if (instret !== 32'd5) begin fails++; $display("FAIL instret_mem: got %0d expected 5", instret); end
`endif
    endtask

    task automatic test_branch_jump();
        logic [31:0] exp_pc [6] = '{32'h100, 32'h104, 32'h10C, 32'h110, 32'h108, 32'h114};
        prog = '{enc_i(1, 0, 0, 1, OPI), enc_b(8, 1, 1, 0), enc_j(12, 0),
                 enc_b(8, 1, 1, 1), enc_j(-8, 7)};
        start_prog(0);
        wait_halt(100, "branch");
        tests++;
        if (fetch_q.size() != fq_base + 6) begin
            fails++; $display("FAIL branch_fetch_count: got %0d expected 6", fetch_q.size() - fq_base);
        end else begin
            for (int i = 0; i < 6; i++) begin
                tests++;
                if (fetch_q[fq_base + i] !== exp_pc[i]) begin
                    fails++; $display("FAIL branch_seq_%0d: got %h expected %h", i, fetch_q[fq_base + i], exp_pc[i]);
                end
            end
            tests++;
            if (fcyc_q[fq_base + 2] - fcyc_q[fq_base + 1] != 3 || fcyc_q[fq_base + 3] - fcyc_q[fq_base + 2] != 3 ||
                fcyc_q[fq_base + 4] - fcyc_q[fq_base + 3] != 4) begin
                fails++; $display("FAIL branch_latency: expected 3,3,4 cycles");
            end
        end
        tests++; if (dut.regs_r[7] !== 32'h114) begin fails++; $display("FAIL jal_link: got %h expected 114", dut.regs_r[7]); end
`ifdef MULTICYCLE_CORE_INSTRET_EN
        tests++; if (instret !== 32'd5) begin fails++; $display("FAIL instret_branch: got %0d expected 5", instret); end
`endif
    endtask

    task automatic test_halt();
        int reqs = 0;
        prog = '{HALT};
        start_prog(0);
        @(posedge clk); #1;
        tests++; if (halted !== 1'b0) begin fails++; $display("FAIL halt_early: got %b expected 0", halted); end
        @(posedge clk); #1;
        tests++; if (halted !== 1'b1) begin fails++; $display("FAIL halt_after_decode: got %b expected 1", halted); end
        repeat (10) begin
            @(negedge clk);
            if (mem_req) reqs++;
        end
        tests++; if (reqs != 0) begin fails++; $display("FAIL halt_req: got %0d request cycles expected 0", reqs); end
        tests++; if (halted !== 1'b1) begin fails++; $display("FAIL halt_absorb: got %b expected 1", halted); end
        rst = 1'b1;
        #1;
        tests++; if (halted !== 1'b0) begin fails++; $display("FAIL halt_rst: got %b expected 0", halted); end
        tests++; if (dut.regs_r[7] !== 32'd0) begin fails++; $display("FAIL rst_regs: got %h expected 0", dut.regs_r[7]); end
        prog = '{};
        start_prog(0);
        #1;
        tests++;
        if (mem_req !== 1'b1 || mem_addr !== RPC) begin
            fails++; $display("FAIL halt_resume: req %b addr %h expected 1 %h", mem_req, mem_addr, RPC);
        end
    endtask

    task automatic test_reset_mid_mem();
        int n = 0;
        prog = '{enc_s(4, 0, 0)};
        start_prog(5);
        while (!mem_we && n < 30) begin
            @(negedge clk);
            n++;
        end
        tests++; if (mem_we !== 1'b1) begin fails++; $display("FAIL mid_mem_reach: got %b expected 1", mem_we); end
        #1;
        rst = 1'b1;
        #1;
        tests++;
        if (mem_req !== 1'b0 || mem_we !== 1'b0) begin
            fails++; $display("FAIL mid_mem_drop: req %b we %b expected 0 0", mem_req, mem_we);
        end
    endtask

    task automatic test_nregs16();
        prog = '{};
        start_prog(0);
        repeat (5) @(negedge clk);
        tests++; if (halted16 !== 1'b1) begin fails++; $display("FAIL nregs16_halt: got %b expected 1", halted16); end
        tests++; if (req16 !== 1'b0) begin fails++; $display("FAIL nregs16_req: got %b expected 0", req16); end
        tests++; if (pc16 !== RPC) begin fails++; $display("FAIL nregs16_pc: got %h expected %h", pc16, RPC); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tests = 0; fails = 0; cyc = 0; wcnt = 0; we_cnt = 0; dwait = 0;
        rst = 1'b1;
        for (int i = 0; i < 64; i++) begin
            imem[i] = HALT;
            dmem[i] = 32'd0;
        end
        test_reset();
        test_alu_basic();
        test_alu_ops();
        test_mem_waits();
        test_branch_jump();
        test_halt();
        test_reset_mid_mem();
        test_nregs16();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
